ra_pq_gen: RTL and testbench

- Parametrised successor to the register-array min-priority queue.
- Adds the following to the earlier single-stage two-phase design:
  - configurable key/value widths and capacity;
  - a selectable throughput mode: two-phase shared sorter, or single-cycle dual-layer sorter;
  - an occupancy counter, synchronous flush, an accept acknowledge, and error pulses.
- Sits between the scheduler front end and consumers of the lowest-key entry.

---
 rtl/ra_pq_gen.sv | 136 +++++++++++++
 tb/tb_ra_pq_gen.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ra_pq_gen.sv
// Register-array min-priority queue: slot 1 (kvo) always holds the lowest key.
// Compare-exchange layers run either in two phases on one sorter (FAST=0) or back to back (FAST=1).
module ra_pq_gen #(
    parameter int KEY_W    = 16,
    parameter int VAL_W    = 16,
    parameter int CAPACITY = 16,
    parameter int FAST     = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enq,
    input  logic                           deq,
    input  logic                           flush,
    input  logic [KEY_W+VAL_W-1:0]         kvi,
    output logic [KEY_W+VAL_W-1:0]         kvo,
    output logic                           ack,
    output logic                           busy,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(CAPACITY+1)-1:0]  count,
    output logic                           err_ovf,
    output logic                           err_udf,
    output logic                           err_key
);
    localparam int KV_W  = KEY_W + VAL_W;
    localparam int CNT_W = $clog2(CAPACITY + 1);
    localparam int IDX_W = $clog2(CAPACITY);
    localparam logic [KEY_W-1:0] KEY_INF  = '1;
    localparam logic [KV_W-1:0]  KV_EMPTY = {KEY_INF, {VAL_W{1'b0}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CAPACITY);

    // Element 0 of the packed array is slot 1.
    typedef logic [CAPACITY-1:0][KV_W-1:0] slots_t;
    localparam slots_t SLOTS_EMPTY = {CAPACITY{KV_EMPTY}};

    slots_t           slots_q, slots_d, loaded, layer_a;
    logic [CNT_W-1:0] count_q, count_d;
    logic             phase_q, phase_d;
    logic             window, key_bad, ovf, udf, live;
    logic             do_ins, do_rep, do_del;

    function automatic logic [KEY_W-1:0] key_of(input logic [KV_W-1:0] kv);
        return kv[KV_W-1 -: KEY_W];
    endfunction

    // One bank of CAPACITY/2 comparators; 'shifted' moves every operand pair up by one
    // slot so the same bank serves the odd layer (1,2).. and the even layer (2,3)..
    function automatic slots_t cx_layer(input slots_t s, input logic shifted);
        slots_t           r;
        logic [IDX_W-1:0] lo, hi;
        r = s;
        for (int k = 0; k < CAPACITY / 2; k++) begin
            lo = IDX_W'(2 * k) | {{(IDX_W-1){1'b0}}, shifted};
            hi = (lo == IDX_W'(CAPACITY - 1)) ? lo : lo + IDX_W'(1);
            if (key_of(s[hi]) < key_of(s[lo])) begin
                r[lo] = s[hi];
                r[hi] = s[lo];
            end
        end
        return r;
    endfunction

    // Insert at slot 1, shifting only up to the first empty slot: a real entry that
    // has not yet bubbled above a sinking empty slot is never pushed off the end.
    function automatic slots_t load_ins(input slots_t s, input logic [KV_W-1:0] kv);
        slots_t r;
        logic   hole;
        r    = s;
        hole = 1'b0;
        for (int i = 1; i < CAPACITY; i++) begin
            if (key_of(s[i-1]) == KEY_INF) hole = 1'b1;
            if (!hole) r[i] = s[i-1];
        end
        r[0] = kv;
        return r;
    endfunction

    // Handshake: enq/deq are level requests sampled every cycle; ack marks the cycle in
    // which the request is taken. While busy=1 requests are ignored and must be held.
    always_comb begin
        window  = (FAST != 0) || !phase_q;
        live    = window && !flush;
        key_bad = enq && (key_of(kvi) == KEY_INF);
        ovf     = enq && !deq && full;
        udf     = deq && !enq && empty;
        err_key = live && key_bad;
        err_ovf = live && !key_bad && ovf;
        err_udf = live && udf;
        ack     = live && (enq || deq) && !key_bad && !ovf && !udf;
        do_ins  = ack && enq && (!deq || empty);
        do_rep  = ack && enq && deq && !empty;
        do_del  = ack && deq && !enq;
    end

    always_comb begin
        slots_d = slots_q;
        count_d = count_q;
        phase_d = phase_q;
        loaded  = slots_q;
        if (do_ins) loaded = load_ins(slots_q, kvi);
        else if (do_rep) loaded[0] = kvi;
        else if (do_del) loaded[0] = KV_EMPTY;
        layer_a = cx_layer(phase_q ? slots_q : loaded, phase_q);
        if (flush) begin
            slots_d = SLOTS_EMPTY;
            count_d = '0;
            phase_d = 1'b0;
        end else if (phase_q) begin
            slots_d = layer_a;
            phase_d = 1'b0;
        end else if (ack) begin
            slots_d = (FAST != 0) ? cx_layer(layer_a, 1'b1) : layer_a;
            phase_d = (FAST == 0);
            if (do_ins) count_d = count_q + CNT_W'(1);
            else if (do_del) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q <= SLOTS_EMPTY;
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            slots_q <= slots_d;
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign kvo   = slots_q[0];
    assign busy  = phase_q;
    assign count = count_q;
    assign full  = (count_q == CNT_MAX);
    assign empty = (count_q == '0);
endmodule

// File: tb/tb_ra_pq_gen.sv
// Bench for ra_pq_gen: four instances (fast/two-phase, capacity 16/4) checked against
// a reference min-queue model through an expected-result queue.
module tb_ra_pq_gen;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst     [N];
    logic        enq     [N];
    logic        deq     [N];
    logic        flush   [N];
    logic [31:0] kvi     [N];
    logic [31:0] kvo     [N];
    logic        ack     [N];
    logic        busy    [N];
    logic        full    [N];
    logic        empty   [N];
    logic [4:0]  count   [N];
    logic        err_ovf [N];
    logic        err_udf [N];
    logic        err_key [N];
    logic [2:0]  cnt_s2, cnt_s3;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] mdl_q [$];
    logic [39:0] exp_q [$];

    // clock / reset block
    always #5 clk = ~clk;

    ra_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(16), .FAST(1)) u_f16 (
        .clk(clk), .rst(rst[0]), .enq(enq[0]), .deq(deq[0]), .flush(flush[0]), .kvi(kvi[0]),
        .kvo(kvo[0]), .ack(ack[0]), .busy(busy[0]), .full(full[0]), .empty(empty[0]),
        .count(count[0]), .err_ovf(err_ovf[0]), .err_udf(err_udf[0]), .err_key(err_key[0]));
    ra_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(16), .FAST(0)) u_s16 (
        .clk(clk), .rst(rst[1]), .enq(enq[1]), .deq(deq[1]), .flush(flush[1]), .kvi(kvi[1]),
        .kvo(kvo[1]), .ack(ack[1]), .busy(busy[1]), .full(full[1]), .empty(empty[1]),
        .count(count[1]), .err_ovf(err_ovf[1]), .err_udf(err_udf[1]), .err_key(err_key[1]));
    ra_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(4), .FAST(1)) u_f4 (
        .clk(clk), .rst(rst[2]), .enq(enq[2]), .deq(deq[2]), .flush(flush[2]), .kvi(kvi[2]),
        .kvo(kvo[2]), .ack(ack[2]), .busy(busy[2]), .full(full[2]), .empty(empty[2]),
        .count(cnt_s2), .err_ovf(err_ovf[2]), .err_udf(err_udf[2]), .err_key(err_key[2]));
    ra_pq_gen #(.KEY_W(16), .VAL_W(16), .CAPACITY(4), .FAST(0)) u_s4 (
        .clk(clk), .rst(rst[3]), .enq(enq[3]), .deq(deq[3]), .flush(flush[3]), .kvi(kvi[3]),
        .kvo(kvo[3]), .ack(ack[3]), .busy(busy[3]), .full(full[3]), .empty(empty[3]),
        .count(cnt_s3), .err_ovf(err_ovf[3]), .err_udf(err_udf[3]), .err_key(err_key[3]));

    assign count[2] = {2'b00, cnt_s2};
    assign count[3] = {2'b00, cnt_s3};

    function automatic int cap_of(input int d);
        return (d >= 2) ? 4 : 16;
    endfunction

    function automatic bit fast_of(input int d);
        return (d == 0) || (d == 2);
    endfunction

    task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int mdl_min_idx();
        int idx = 0;
        for (int i = 1; i < mdl_q.size(); i++)
            if (mdl_q[i] < mdl_q[idx]) idx = i;
        return idx;
    endfunction

    function automatic logic [31:0] mdl_kvo();
        logic [15:0] k;
        if (mdl_q.size() == 0) return {16'hFFFF, 16'h0000};
        k = mdl_q[mdl_min_idx()];
        return {k, k ^ 16'hA5A5};
    endfunction

    // driver tasks
    task automatic do_reset(input int d);
        rst[d] = 1'b1; enq[d] = 1'b0; deq[d] = 1'b0; flush[d] = 1'b0; kvi[d] = '0;
        @(negedge clk);
        @(negedge clk);
        rst[d] = 1'b0;
        mdl_q.delete();
        exp_q.delete();
    endtask

    // Caller is between a negedge and the next posedge. One request, then check the result.
    task automatic op(input int d, input logic e, input logic q, input logic f, input logic [15:0] key);
        logic        x_ack, x_key, x_ovf, x_udf;
        int          cnt;
        logic [39:0] sb;
        enq[d] = e; deq[d] = q; flush[d] = f; kvi[d] = {key, key ^ 16'hA5A5};
        cnt   = mdl_q.size();
        x_key = !f && e && (key == 16'hFFFF);
        x_ovf = !f && !x_key && e && !q && (cnt == cap_of(d));
        x_udf = !f && q && !e && (cnt == 0);
        x_ack = !f && (e || q) && !x_key && !x_ovf && !x_udf;
        #1;
        check_eq($sformatf("u%0d ack", d), ack[d], x_ack);
        check_eq($sformatf("u%0d err_key", d), err_key[d], x_key);
        check_eq($sformatf("u%0d err_ovf", d), err_ovf[d], x_ovf);
        check_eq($sformatf("u%0d err_udf", d), err_udf[d], x_udf);
        if (f) mdl_q.delete();
        else if (x_ack) begin
            if (q && cnt > 0) mdl_q.delete(mdl_min_idx());
            if (e) mdl_q.push_back(key);
        end
        exp_q.push_back({8'(mdl_q.size()), mdl_kvo()});
        @(posedge clk);
        @(negedge clk);
        enq[d] = 1'b0; deq[d] = 1'b0; flush[d] = 1'b0;
        if (!fast_of(d) && x_ack) begin
            #1;
            check_eq($sformatf("u%0d busy_ph1", d), busy[d], 1'b1);
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        sb = exp_q.pop_front();
        check_eq($sformatf("u%0d kvo", d), kvo[d], sb[31:0]);
        check_eq($sformatf("u%0d count", d), count[d], sb[36:32]);
        check_eq($sformatf("u%0d empty", d), empty[d], sb[39:32] == 0);
        check_eq($sformatf("u%0d full", d), full[d], sb[39:32] == 8'(cap_of(d)));
        check_eq($sformatf("u%0d busy", d), busy[d], 1'b0);
    endtask

    task automatic check_cleared(input int d, input string tag);
        check_eq($sformatf("u%0d %s kvo", d, tag), kvo[d], {16'hFFFF, 16'h0000});
        check_eq($sformatf("u%0d %s count", d, tag), count[d], 0);
        check_eq($sformatf("u%0d %s empty", d, tag), empty[d], 1'b1);
        check_eq($sformatf("u%0d %s busy", d, tag), busy[d], 1'b0);
    endtask

    initial begin
        int          r;
        logic [15:0] key;
        logic        heavy;
        for (int d = 0; d < N; d++) begin
            rst[d] = 1'b1; enq[d] = 1'b0; deq[d] = 1'b0; flush[d] = 1'b0; kvi[d] = '0;
        end
        #12;
        for (int d = 0; d < N; d++) check_cleared(d, "in_rst");
        @(negedge clk);
        for (int d = 0; d < N; d++) rst[d] = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #1;
            for (int d = 0; d < N; d++) check_cleared(d, "idle");
        end

        // fast mode: consecutive enqueues then drain
        do_reset(0);
        op(0, 1, 0, 0, 16'd9); op(0, 1, 0, 0, 16'd3); op(0, 1, 0, 0, 16'd7); op(0, 1, 0, 0, 16'd1);
        repeat (4) op(0, 0, 1, 0, 16'd0);
        // error cases
        op(0, 0, 1, 0, 16'd0);
        op(0, 1, 0, 0, 16'hFFFF);
        op(0, 1, 1, 0, 16'd8);
        op(0, 1, 1, 0, 16'hFFFF);
        op(0, 1, 0, 1, 16'd4);

        // two-phase mode: held enqueue is ignored while busy
        do_reset(1);
        enq[1] = 1'b1; kvi[1] = {16'd5, 16'h0};
        #1 check_eq("hold ack1", ack[1], 1'b1);
        @(posedge clk); @(negedge clk);
        kvi[1] = {16'd2, 16'h0};
        #1 check_eq("hold busy1", busy[1], 1'b1);
        check_eq("hold ack_busy", ack[1], 1'b0);
        @(posedge clk); @(negedge clk);
        #1 check_eq("hold busy0", busy[1], 1'b0);
        check_eq("hold kvo5", kvo[1][31:16], 16'd5);
        check_eq("hold ack2", ack[1], 1'b1);
        @(posedge clk); @(negedge clk);
        enq[1] = 1'b0;
        #1 check_eq("hold busy2", busy[1], 1'b1);
        @(posedge clk); @(negedge clk);
        #1 check_eq("hold kvo2", kvo[1][31:16], 16'd2);
        check_eq("hold count2", count[1], 5'd2);

        // flush during phase 1
        do_reset(1);
        op(1, 1, 0, 0, 16'd30); op(1, 1, 0, 0, 16'd10); op(1, 1, 0, 0, 16'd20);
        enq[1] = 1'b1; kvi[1] = {16'd4, 16'h0};
        #1 check_eq("fl ack", ack[1], 1'b1);
        @(posedge clk); @(negedge clk);
        enq[1] = 1'b0; flush[1] = 1'b1;
        #1 check_eq("fl busy", busy[1], 1'b1);
        check_eq("fl ack_busy", ack[1], 1'b0);
        @(posedge clk); @(negedge clk);
        flush[1] = 1'b0;
        #1 check_cleared(1, "flush");
        mdl_q.delete();

        // asynchronous reset mid-sort
        op(1, 1, 0, 0, 16'd30); op(1, 1, 0, 0, 16'd10); op(1, 1, 0, 0, 16'd20);
        enq[1] = 1'b1; kvi[1] = {16'd4, 16'h0};
        @(posedge clk);
        #2 rst[1] = 1'b1;
        #1 check_cleared(1, "arst");
        @(negedge clk);
        enq[1] = 1'b0; rst[1] = 1'b0;
        mdl_q.delete();

        // capacity 4: overflow then replace
        do_reset(2);
        op(2, 1, 0, 0, 16'd10); op(2, 1, 0, 0, 16'd20); op(2, 1, 0, 0, 16'd30); op(2, 1, 0, 0, 16'd40);
        op(2, 1, 0, 0, 16'd5);
        op(2, 1, 1, 0, 16'd25);

        // random operations against the model, 2500 per instance
        for (int d = 0; d < N; d++) begin
            do_reset(d);
            for (int i = 0; i < 2500; i++) begin
                heavy = ((i / 150) % 2) == 0;
                r     = $urandom_range(0, 99);
                key   = ($urandom_range(0, 40) == 0) ? 16'hFFFF : 16'($urandom_range(0, 60));
                if (r < 2) op(d, 1'b0, 1'b0, 1'b1, key);
                else if (r < (heavy ? 60 : 30)) op(d, 1'b1, 1'b0, 1'b0, key);
                else if (r < (heavy ? 80 : 75)) op(d, 1'b0, 1'b1, 1'b0, key);
                else op(d, 1'b1, 1'b1, 1'b0, key);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
